// File: rtl/riscv_selftest_ctrl_if.sv
// riscv_selftest_ctrl_if
// Connection between the self-test controller and the core under test.
//   core_rst   controller -> core   reset to the core
//   dbg_raddr  controller -> core   debug register-read address
//   pc_in      core -> controller   current core PC
//   dbg_rdata  core -> controller   combinational read data for dbg_raddr
// master: controller side, slave: core side.
interface riscv_selftest_ctrl_if #(
    parameter int XLEN = 32
);
    logic            core_rst;
    logic [4:0]      dbg_raddr;
    logic [XLEN-1:0] pc_in;
    logic [XLEN-1:0] dbg_rdata;

    modport master (
        output core_rst,
        output dbg_raddr,
        input  pc_in,
        input  dbg_rdata
    );

    modport slave (
        input  core_rst,
        input  dbg_raddr,
        output pc_in,
        output dbg_rdata
    );
endinterface

// File: rtl/riscv_selftest_ctrl.sv
// riscv_selftest_ctrl
// Self-test sequencer for the single-cycle RISC-V core. Holds the core in
// reset, releases it after a reset-hold, waits for a PC self-loop (halt) or
// a timeout, then walks the check table through the debug read port.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   start                            begin a test (honoured in IDLE/DONE)
//   chk_we/chk_idx/chk_en/chk_reg/chk_val  check-table write port (IDLE/DONE)
//   core                             core-side interface (master)
//   busy, done                       status
//   pass, timed_out                  results, valid while done
//   fail_count, first_fail_idx       mismatch count, lowest failing slot
//   cycle_count                      RUN cycles consumed
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | core held in reset, table writable
// RST_HOLD | core held in reset for RST_HOLD_CYCLES more cycles
// RUN      | core running; watching for PC self-loop or timeout
// CHECK    | core parked on its halt loop; one table slot per cycle
// DONE     | results held, core back in reset, table writable
module riscv_selftest_ctrl #(
    parameter int XLEN            = 32,
    parameter int NUM_CHECKS      = 8,
    parameter int RST_HOLD_CYCLES = 2,
    parameter int HALT_STABLE     = 3,
    parameter int TIMEOUT_CYCLES  = 50
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                chk_we,
    input  logic [$clog2(NUM_CHECKS)-1:0]       chk_idx,
    input  logic                                chk_en,
    input  logic [4:0]                          chk_reg,
    input  logic [XLEN-1:0]                     chk_val,
    riscv_selftest_ctrl_if.master               core,
    output logic                                busy,
    output logic                                done,
    output logic                                pass,
    output logic                                timed_out,
    output logic [$clog2(NUM_CHECKS+1)-1:0]     fail_count,
    output logic [$clog2(NUM_CHECKS)-1:0]       first_fail_idx,
    output logic [$clog2(TIMEOUT_CYCLES+1)-1:0] cycle_count
);
    localparam int IW = $clog2(NUM_CHECKS);
    localparam int FW = $clog2(NUM_CHECKS + 1);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HW = $clog2(HALT_STABLE);
    localparam int RW = $clog2(RST_HOLD_CYCLES + 1);

    localparam logic [IW-1:0] LAST_SLOT = IW'(NUM_CHECKS - 1);
    localparam logic [FW-1:0] FAIL_MAX  = FW'(NUM_CHECKS);
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT_CYCLES);
    localparam logic [HW-1:0] HALT_C    = HW'(HALT_STABLE - 1);
    localparam logic [RW-1:0] HOLD_LOAD = RW'(RST_HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_HOLD,
        S_RUN,
        S_CHECK,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [NUM_CHECKS-1:0] tbl_en;
    logic [4:0]            tbl_reg [NUM_CHECKS];
    logic [XLEN-1:0]       tbl_val [NUM_CHECKS];

    logic [RW-1:0]   hold_cnt;
    logic [HW-1:0]   stable_cnt;
    logic [HW-1:0]   stable_nxt;
    logic            run_first;
    logic [XLEN-1:0] prev_pc;
    logic [IW-1:0]   chk_ptr;
    logic [CW-1:0]   cycle_inc;
    logic            halt_hit;
    logic            timeout_hit;
    logic            slot_fail;
    logic            tbl_wr_ok;
    logic            core_rst_c;
    logic [4:0]      dbg_raddr_c;

    // prev_pc is stale on the first RUN cycle, so that cycle never counts
    // toward the stable-PC run.
    always_comb begin
        stable_nxt = '0;
        if (!run_first && (core.pc_in == prev_pc))
            stable_nxt = (stable_cnt == HALT_C) ? stable_cnt : stable_cnt + 1'b1;
        halt_hit    = (stable_nxt == HALT_C);
        cycle_inc   = (cycle_count == TIMEOUT_C) ? cycle_count : cycle_count + 1'b1;
        timeout_hit = (cycle_inc == TIMEOUT_C);
        slot_fail   = tbl_en[chk_ptr] && (core.dbg_rdata != tbl_val[chk_ptr]);
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        core_rst_c  = 1'b1;
        dbg_raddr_c = '0;
        busy        = 1'b0;
        done        = 1'b0;
        tbl_wr_ok   = 1'b0;
        case (state)
            S_IDLE: begin
                tbl_wr_ok = 1'b1;
                if (start)
                    state_nxt = S_RST_HOLD;
            end
            S_RST_HOLD: begin
                busy = 1'b1;
                if (hold_cnt == '0)
                    state_nxt = S_RUN;
            end
            S_RUN: begin
                busy       = 1'b1;
                core_rst_c = 1'b0;
                // halt takes priority when both land on the same cycle
                if (halt_hit)
                    state_nxt = S_CHECK;
                else if (timeout_hit)
                    state_nxt = S_DONE;
            end
            S_CHECK: begin
                busy        = 1'b1;
                core_rst_c  = 1'b0;
                dbg_raddr_c = tbl_reg[chk_ptr];
                if (chk_ptr == LAST_SLOT)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                tbl_wr_ok = 1'b1;
                if (start)
                    state_nxt = S_RST_HOLD;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tbl_en <= '0;
            for (int i = 0; i < NUM_CHECKS; i++) begin
                tbl_reg[i] <= '0;
                tbl_val[i] <= '0;
            end
            hold_cnt       <= '0;
            stable_cnt     <= '0;
            run_first      <= 1'b1;
            prev_pc        <= '0;
            chk_ptr        <= '0;
            cycle_count    <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            timed_out      <= 1'b0;
        end else begin
            // a write coinciding with start lands before CHECK reads it
            if (tbl_wr_ok && chk_we) begin
                tbl_en[chk_idx]  <= chk_en;
                tbl_reg[chk_idx] <= chk_reg;
                tbl_val[chk_idx] <= chk_val;
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        hold_cnt       <= HOLD_LOAD;
                        cycle_count    <= '0;
                        fail_count     <= '0;
                        first_fail_idx <= '0;
                        timed_out      <= 1'b0;
                    end
                end
                S_RST_HOLD: begin
                    if (hold_cnt != '0)
                        hold_cnt <= hold_cnt - 1'b1;
                    stable_cnt <= '0;
                    run_first  <= 1'b1;
                    chk_ptr    <= '0;
                end
                S_RUN: begin
                    cycle_count <= cycle_inc;
                    prev_pc     <= core.pc_in;
                    run_first   <= 1'b0;
                    stable_cnt  <= stable_nxt;
                    if (!halt_hit && timeout_hit)
                        timed_out <= 1'b1;
                end
                S_CHECK: begin
                    if (slot_fail) begin
                        if (fail_count == '0)
                            first_fail_idx <= chk_ptr;
                        if (fail_count != FAIL_MAX)
                            fail_count <= fail_count + 1'b1;
                    end
                    if (chk_ptr != LAST_SLOT)
                        chk_ptr <= chk_ptr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign pass           = done && !timed_out && (fail_count == '0);
    assign core.core_rst  = core_rst_c;
    assign core.dbg_raddr = dbg_raddr_c;
endmodule

// File: tb/tb_riscv_selftest_ctrl.sv
// tb_riscv_selftest_ctrl
// Drives the self-test controller against a tiny core stand-in (PC counts by 4
// until it reaches halt_pc, then self-loops; register file read
// combinationally). Expected results come from the halt/timeout/check rules
// applied arithmetically to the bench's own copy of the table.
module tb_riscv_selftest_ctrl;
    localparam int XLEN = 32;
    localparam int NC   = 8;
    localparam int RH   = 2;
    localparam int HS   = 3;
    localparam int TO   = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        chk_we = 1'b0;
    logic [2:0]  chk_idx = '0;
    logic        chk_en = 1'b0;
    logic [4:0]  chk_reg = '0;
    logic [31:0] chk_val = '0;
    logic        busy, done, pass, timed_out;
    logic [3:0]  fail_count;
    logic [2:0]  first_fail_idx;
    logic [5:0]  cycle_count;

    riscv_selftest_ctrl_if #(.XLEN(XLEN)) bus ();

    riscv_selftest_ctrl #(
        .XLEN(XLEN), .NUM_CHECKS(NC), .RST_HOLD_CYCLES(RH),
        .HALT_STABLE(HS), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .chk_we(chk_we), .chk_idx(chk_idx), .chk_en(chk_en),
        .chk_reg(chk_reg), .chk_val(chk_val),
        .core(bus),
        .busy(busy), .done(done), .pass(pass), .timed_out(timed_out),
        .fail_count(fail_count), .first_fail_idx(first_fail_idx),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // core stand-in
    logic [31:0] core_pc = '0;
    logic [31:0] halt_pc = '0;
    logic [31:0] regs [32];

    always @(posedge clk) begin
        if (bus.core_rst)
            core_pc <= '0;
        else if (core_pc != halt_pc)
            core_pc <= core_pc + 32'd4;
    end
    assign bus.pc_in     = core_pc;
    assign bus.dbg_rdata = regs[bus.dbg_raddr];

    // bench copy of the check table
    bit          m_en  [NC];
    int          m_reg [NC];
    logic [31:0] m_val [NC];

    int n_tests = 0;
    int n_fail  = 0;
    int last_cycles = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_model(input int r);
        return (r == 0) ? 32'd0 : regs[r];
    endfunction

    task automatic write_slot(input int idx, input bit en, input int r, input logic [31:0] v);
        chk_we  = 1'b1;
        chk_idx = 3'(idx);
        chk_en  = en;
        chk_reg = 5'(r);
        chk_val = v;
        @(posedge clk); #1;
        chk_we = 1'b0;
        m_en[idx]  = en;
        m_reg[idx] = r;
        m_val[idx] = v;
    endtask

    // mode 0: plain run; 1: start+write injected during RUN;
    // 2: rst pulsed during CHECK; 3: table write in the same cycle as start
    task automatic run_case(input string name, input int mode);
        int h, exp_n, exp_fail, exp_first, k, hi, lo, bsy, tail;
        bit exp_to, exp_pass, seen_raddr, got_done, injected;
        if (mode == 3) begin
            chk_we  = 1'b1;
            chk_idx = 3'd7;
            chk_en  = 1'b1;
            chk_reg = 5'd3;
            chk_val = 32'd7;
            m_en[7] = 1'b1; m_reg[7] = 3; m_val[7] = 32'd7;
        end
        h      = int'(halt_pc >> 2);
        exp_to = (h + HS > TO);
        exp_n  = exp_to ? TO : h + HS;
        exp_fail = 0;
        exp_first = 0;
        if (!exp_to) begin
            for (int i = 0; i < NC; i++) begin
                if (m_en[i] && rd_model(m_reg[i]) != m_val[i]) begin
                    if (exp_fail == 0) exp_first = i;
                    exp_fail++;
                end
            end
        end
        exp_pass = !exp_to && (exp_fail == 0);
        tail = exp_to ? 0 : NC;

        start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        chk_we = 1'b0;
        k = 0; hi = 0; lo = 0; bsy = 0;
        seen_raddr = 0; got_done = 0; injected = 0;
        while (k < 400) begin
            if (done) begin
                got_done = 1;
                break;
            end
            if (bus.core_rst) hi++; else lo++;
            if (busy) bsy++;
            if (bus.dbg_raddr != 5'd0) seen_raddr = 1;
            if (mode == 1 && !bus.core_rst && !injected) begin
                start = 1'b1; chk_we = 1'b1; chk_idx = 3'd0;
                chk_en = 1'b1; chk_reg = 5'd1; chk_val = 32'd99;
                injected = 1;
            end
            if (mode == 2 && k == RH + exp_n + 3)
                rst = 1'b1;
            @(posedge clk); #1;
            start  = 1'b0;
            chk_we = 1'b0;
            if (rst) begin
                rst = 1'b0;
                check_val({name, ".core_rst"}, 64'(bus.core_rst), 64'(1));
                check_val({name, ".done"}, 64'(done), 64'(0));
                check_val({name, ".busy"}, 64'(busy), 64'(0));
                check_val({name, ".pass"}, 64'(pass), 64'(0));
                check_val({name, ".fail_count"}, 64'(fail_count), 64'(0));
                check_val({name, ".cycle_count"}, 64'(cycle_count), 64'(0));
                for (int i = 0; i < NC; i++) m_en[i] = 1'b0;
                return;
            end
            k++;
        end
        check_val({name, ".reached_done"}, 64'(got_done), 64'(1));
        check_val({name, ".latency"}, 64'(k), 64'(RH + exp_n + tail));
        check_val({name, ".rst_hold"}, 64'(hi), 64'(RH));
        check_val({name, ".rst_low"}, 64'(lo), 64'(exp_n + tail));
        check_val({name, ".busy_cycles"}, 64'(bsy), 64'(RH + exp_n + tail));
        if (exp_to)
            check_val({name, ".raddr_walked"}, 64'(seen_raddr), 64'(0));
        check_val({name, ".pass"}, 64'(pass), 64'(exp_pass));
        check_val({name, ".timed_out"}, 64'(timed_out), 64'(exp_to));
        check_val({name, ".fail_count"}, 64'(fail_count), 64'(exp_fail));
        check_val({name, ".first_fail"}, 64'(first_fail_idx), 64'(exp_first));
        check_val({name, ".cycle_count"}, 64'(cycle_count), 64'(exp_n));
        check_val({name, ".done_core_rst"}, 64'(bus.core_rst), 64'(1));
        check_val({name, ".done_busy"}, 64'(busy), 64'(0));
        last_cycles = int'(cycle_count);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        for (int i = 0; i < 32; i++) regs[i] = '0;
        for (int i = 0; i < NC; i++) begin
            m_en[i] = 1'b0; m_reg[i] = 0; m_val[i] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset.core_rst", 64'(bus.core_rst), 64'(1));
        check_val("reset.dbg_raddr", 64'(bus.dbg_raddr), 64'(0));
        check_val("reset.busy", 64'(busy), 64'(0));
        check_val("reset.done", 64'(done), 64'(0));
        check_val("reset.pass", 64'(pass), 64'(0));
        check_val("reset.timed_out", 64'(timed_out), 64'(0));
        check_val("reset.fail_count", 64'(fail_count), 64'(0));
        check_val("reset.first_fail", 64'(first_fail_idx), 64'(0));
        check_val("reset.cycle_count", 64'(cycle_count), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        regs[1] = 32'd5; regs[2] = 32'd10; regs[3] = 32'd15;
        write_slot(0, 1'b1, 1, 32'd5);
        write_slot(1, 1'b1, 2, 32'd10);
        write_slot(2, 1'b1, 3, 32'd15);
        halt_pc = 32'h20;
        run_case("basic", 0);

        write_slot(2, 1'b1, 3, 32'd16);
        run_case("slot2_bad", 0);

        write_slot(2, 1'b1, 3, 32'd15);
        halt_pc = 32'h1000;
        run_case("timeout", 0);

        halt_pc = 32'h20;
        run_case("inject_run", 1);
        prev = last_cycles;
        run_case("restart", 0);
        check_val("restart.same_cycles", 64'(last_cycles), 64'(prev));

        halt_pc = 32'(4 * (TO - HS));
        run_case("halt_at_limit", 0);
        halt_pc = 32'(4 * (TO - HS + 1));
        run_case("timeout_by_one", 0);
        halt_pc = 32'h0;
        run_case("halt_at_zero", 0);

        halt_pc = 32'h20;
        run_case("wr_with_start", 3);
        run_case("rst_in_check", 2);
        run_case("empty_table", 0);

        for (int it = 0; it < 20; it++) begin
            for (int r = 1; r < 32; r++) regs[r] = $urandom;
            for (int s = 0; s < NC; s++) begin
                int rr;
                logic [31:0] vv;
                rr = int'($urandom_range(0, 31));
                vv = ($urandom_range(0, 3) == 0) ? $urandom : rd_model(rr);
                write_slot(s, 1'($urandom_range(0, 1)), rr, vv);
            end
            halt_pc = 32'(4 * $urandom_range(0, TO - HS + 3));
            run_case($sformatf("rand%0d", it), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
